// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: operation encodings and FSM state names.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_FWD = 4'h0,
    OP_ADD = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_SUB = 4'h4,
    OP_SLL = 4'h5,
    OP_SRL = 4'h6,
    OP_SRA = 4'h7,
    OP_ROR = 4'h8,
    OP_MUL = 4'h9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the execute-stage control and the multicycle ALU.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 8
) ();
  import alu_pkg::*;

  logic                 IN_VALID;
  logic                 IN_READY;
  logic [OP_W-1:0]      OP;
  logic [WIDTH-1:0]     DATA1;
  logic [WIDTH-1:0]     DATA2;
  logic                 OUT_VALID;
  logic [WIDTH-1:0]     RESULT;
  logic                 ZERO;
  logic                 NEG;
  logic                 CARRY;
  logic                 OVERFLOW;

  modport master (
    output IN_VALID, OP, DATA1, DATA2,
    input  IN_READY, OUT_VALID, RESULT, ZERO, NEG, CARRY, OVERFLOW
  );

  modport slave (
    input  IN_VALID, OP, DATA1, DATA2,
    output IN_READY, OUT_VALID, RESULT, ZERO, NEG, CARRY, OVERFLOW
  );

endinterface

// File: rtl/alu_comb_unit.sv
// Single-cycle datapath: FWD/ADD/AND/OR/SUB with carry, borrow and signed overflow.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             overflow_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    result_c   = b;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    case (op)
      OP_ADD: begin
        result_c   = sum[WIDTH-1:0];
        carry_c    = sum[WIDTH];
        overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result_c = a & b;
      OP_OR:  result_c = a | b;
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        result_c   = diff[WIDTH-1:0];
        carry_c    = diff[WIDTH];
        overflow_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: result_c = b;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU: single-cycle ops via alu_comb_unit, bit-serial shifts and shift-add multiply.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  multicycle_alu_if.slave  bus
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned CNT_W = SHW + 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_BUSY = 2'(BUSY);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]         state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH-1:0]   comb_result;
  logic               comb_carry;
  logic               comb_overflow;

  logic [SHW-1:0]     shamt;
  logic               in_is_shift;
  logic [WIDTH-1:0]   sh_v;
  logic [WIDTH-1:0]   step_val;
  logic               step_out;
  logic [WIDTH:0]     mul_sum;
  logic               upd;

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .op         (bus.OP),
    .a          (bus.DATA1),
    .b          (bus.DATA2),
    .result_c   (comb_result),
    .carry_c    (comb_carry),
    .overflow_c (comb_overflow)
  );

  // Next-state, datapath iteration and result/flag update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    upd         = 1'b0;

    shamt       = bus.DATA2[SHW-1:0];
    in_is_shift = (bus.OP == OP_SLL) || (bus.OP == OP_SRL) ||
                  (bus.OP == OP_SRA) || (bus.OP == OP_ROR);

    // One shift/rotate step on the low half of the accumulator.
    sh_v     = acc_q[WIDTH-1:0];
    step_val = sh_v;
    step_out = 1'b0;
    case (op_q)
      OP_SLL: begin step_val = {sh_v[WIDTH-2:0], 1'b0};       step_out = sh_v[WIDTH-1]; end
      OP_SRL: begin step_val = {1'b0, sh_v[WIDTH-1:1]};       step_out = sh_v[0];       end
      OP_SRA: begin step_val = {sh_v[WIDTH-1], sh_v[WIDTH-1:1]}; step_out = sh_v[0];    end
      OP_ROR: begin step_val = {sh_v[0], sh_v[WIDTH-1:1]};    step_out = 1'b0;          end
      default: ;
    endcase

    // Right-shifting shift-add: high half accumulates, low half holds remaining multiplier bits.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};

    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          op_d = bus.OP;
          a_d  = bus.DATA1;
          if (bus.OP == OP_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, bus.DATA2};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_BUSY;
          end else if (in_is_shift && (shamt != '0)) begin
            acc_d   = {{WIDTH{1'b0}}, bus.DATA1};
            cnt_d   = CNT_W'(shamt);
            state_d = S_BUSY;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            upd         = 1'b1;
            result_d    = in_is_shift ? bus.DATA1 : comb_result;
            carry_d     = in_is_shift ? 1'b0 : comb_carry;
            overflow_d  = in_is_shift ? 1'b0 : comb_overflow;
          end
        end
      end
      S_BUSY: begin
        if (op_q == OP_MUL) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], step_val};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          upd         = 1'b1;
          result_d    = acc_d[WIDTH-1:0];
          carry_d     = (op_q == OP_MUL) ? (|acc_d[2*WIDTH-1:WIDTH]) : step_out;
          overflow_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (upd) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
    end

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESULT    = result_q;
  assign bus.ZERO      = zero_q;
  assign bus.NEG       = neg_q;
  assign bus.CARRY     = carry_q;
  assign bus.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH = 8.
module tb_multicycle_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_alu_if #(.WIDTH(8)) bus ();

  multicycle_alu #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waits (bounded) for IN_READY, presents the request and returns the accepting cycle.
  task automatic issue(input logic [3:0] op, input logic [7:0] d1, input logic [7:0] d2,
                       input bit hold, output int acc_cyc);
    int w = 0;
    while (bus.IN_READY !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    if (w >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: IN_READY=%b required 1", bus.IN_READY);
    end
    bus.OP = op; bus.DATA1 = d1; bus.DATA2 = d2; bus.IN_VALID = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) bus.IN_VALID = 1'b0;
  endtask

  // Latency in cycles from the accepting edge; -1 if OUT_VALID never rises.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.OUT_VALID === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_tests++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.IN_READY); end
    n_tests++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.OUT_VALID); end
    n_tests++; if (bus.RESULT !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", bus.RESULT); end
    n_tests++; if ({bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW}); end
  endtask

  task automatic test_add();
    int a, lat;
    issue(4'h1, 8'h7F, 8'h01, 1'b0, a);
    wait_done(lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_tests++; if (bus.RESULT !== 8'h80) begin n_fail++; $display("FAIL add_result: got %h want 80", bus.RESULT); end
    n_tests++; if ({bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW} !== 4'b0101) begin n_fail++;
      $display("FAIL add_flags(ZNCV): got %b want 0101", {bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW}); end
    @(negedge clk);
    n_tests++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL add_pulse_width: got %b want 0", bus.OUT_VALID); end
    n_tests++; if (bus.RESULT !== 8'h80) begin n_fail++; $display("FAIL add_hold: got %h want 80", bus.RESULT); end
  endtask

  task automatic test_sub_back_to_back();
    int a1, a2, lat;
    issue(4'h4, 8'h05, 8'h05, 1'b0, a1);
    wait_done(lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL sub0_latency: got %0d want 1", lat); end
    n_tests++; if (bus.RESULT !== 8'h00) begin n_fail++; $display("FAIL sub0_result: got %h want 00", bus.RESULT); end
    n_tests++; if ({bus.ZERO, bus.CARRY} !== 2'b10) begin n_fail++; $display("FAIL sub0_flags(ZC): got %b want 10", {bus.ZERO, bus.CARRY}); end
    issue(4'h4, 8'h03, 8'h04, 1'b0, a2);
    n_tests++; if (a2 - a1 !== 2) begin n_fail++; $display("FAIL sub_issue_interval: got %0d want 2", a2 - a1); end
    wait_done(lat);
    n_tests++; if (bus.RESULT !== 8'hFF) begin n_fail++; $display("FAIL sub1_result: got %h want ff", bus.RESULT); end
    n_tests++; if ({bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW} !== 4'b0110) begin n_fail++;
      $display("FAIL sub1_flags(ZNCV): got %b want 0110", {bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW}); end
  endtask

  task automatic test_shift();
    int a, lat;
    issue(4'h7, 8'h90, 8'h03, 1'b0, a);
    wait_done(lat);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL sra_latency: got %0d want 4", lat); end
    n_tests++; if (bus.RESULT !== 8'hF2) begin n_fail++; $display("FAIL sra_result: got %h want f2", bus.RESULT); end
    n_tests++; if ({bus.NEG, bus.CARRY} !== 2'b10) begin n_fail++; $display("FAIL sra_flags(NC): got %b want 10", {bus.NEG, bus.CARRY}); end
    issue(4'h5, 8'h81, 8'h00, 1'b0, a);
    wait_done(lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL sll0_latency: got %0d want 1", lat); end
    n_tests++; if (bus.RESULT !== 8'h81) begin n_fail++; $display("FAIL sll0_result: got %h want 81", bus.RESULT); end
    issue(4'h8, 8'h81, 8'h01, 1'b0, a);
    wait_done(lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ror_latency: got %0d want 2", lat); end
    n_tests++; if (bus.RESULT !== 8'hC0) begin n_fail++; $display("FAIL ror_result: got %h want c0", bus.RESULT); end
    issue(4'h5, 8'h41, 8'h02, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, bus.CARRY} !== {8'h04, 1'b1}) begin n_fail++;
      $display("FAIL sll2_result_carry: got %h/%b want 04/1", bus.RESULT, bus.CARRY); end
    issue(4'h6, 8'h81, 8'h07, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, bus.CARRY, 6'(lat)} !== {8'h01, 1'b0, 6'd8}) begin n_fail++;
      $display("FAIL srl7_result_carry_lat: got %h/%b/%0d want 01/0/8", bus.RESULT, bus.CARRY, lat); end
  endtask

  task automatic test_mul();
    int a, lat;
    issue(4'h9, 8'h0F, 8'h11, 1'b0, a);
    wait_done(lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL mul0_latency: got %0d want 9", lat); end
    n_tests++; if ({bus.RESULT, bus.CARRY} !== {8'hFF, 1'b0}) begin n_fail++;
      $display("FAIL mul0_result_carry: got %h/%b want ff/0", bus.RESULT, bus.CARRY); end
    issue(4'h9, 8'h10, 8'h10, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, bus.ZERO, bus.CARRY} !== {8'h00, 1'b1, 1'b1}) begin n_fail++;
      $display("FAIL mul1_result_zc: got %h/%b%b want 00/11", bus.RESULT, bus.ZERO, bus.CARRY); end
  endtask

  task automatic test_busy_ignore();
    int a, lat = -1, bad = 0;
    issue(4'h9, 8'h03, 8'h05, 1'b1, a);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.IN_READY !== 1'b0) bad++;
      if (bus.OUT_VALID === 1'b1) begin lat = i; bus.IN_VALID = 1'b0; break; end
      bus.OP = (i % 2 == 0) ? 4'h1 : 4'h9;
      bus.DATA1 = 8'(8'hA0 + i); bus.DATA2 = 8'(8'h50 + i);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL busy_ready_low: got %0d ready cycles want 0", bad); end
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL busy_latency: got %0d want 9", lat); end
    n_tests++; if (bus.RESULT !== 8'h0F) begin n_fail++; $display("FAIL busy_result: got %h want 0f", bus.RESULT); end
  endtask

  task automatic test_reset_mid();
    int a, lat, seen = 0;
    issue(4'h9, 8'hFF, 8'hFF, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, bus.CARRY} !== {8'h01, 1'b1}) begin n_fail++;
      $display("FAIL mulff_result_carry: got %h/%b want 01/1", bus.RESULT, bus.CARRY); end
    issue(4'h9, 8'h07, 8'h06, 1'b0, a);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_tests++; if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.IN_READY); end
    n_tests++; if ({bus.OUT_VALID, bus.RESULT, bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW} !== 13'h0) begin n_fail++;
      $display("FAIL rstmid_outputs: got v=%b r=%h zncv=%b%b%b%b want all 0", bus.OUT_VALID, bus.RESULT,
               bus.ZERO, bus.NEG, bus.CARRY, bus.OVERFLOW); end
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus.OUT_VALID === 1'b1) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); end
    issue(4'h1, 8'h02, 8'h03, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, 6'(lat)} !== {8'h05, 6'd1}) begin n_fail++;
      $display("FAIL rstmid_add: got %h lat %0d want 05 lat 1", bus.RESULT, lat); end
  endtask

  task automatic test_undef();
    int a, lat;
    issue(4'hF, 8'h33, 8'h5A, 1'b0, a);
    wait_done(lat);
    n_tests++; if ({bus.RESULT, 6'(lat)} !== {8'h5A, 6'd1}) begin n_fail++;
      $display("FAIL undef_fwd: got %h lat %0d want 5a lat 1", bus.RESULT, lat); end
    n_tests++; if ({bus.CARRY, bus.OVERFLOW} !== 2'b00) begin n_fail++;
      $display("FAIL undef_flags(CV): got %b%b want 00", bus.CARRY, bus.OVERFLOW); end
  endtask

  initial begin
    bus.IN_VALID = 1'b0; bus.OP = 4'h0; bus.DATA1 = 8'h00; bus.DATA2 = 8'h00;
    test_reset();
    test_add();
    test_sub_back_to_back();
    test_shift();
    test_mul();
    test_busy_ignore();
    test_reset_mid();
    test_undef();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the CPU's 8-bit combinational ALU. Executes the legacy ops (forward, add, and, or) plus subtract, shifts, rotate and an iterative multiply behind a valid/ready handshake, with registered result and flags. Sits in the execute stage; the control unit stalls the PC while `IN_READY` is low.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; power of two, at least 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived, not overridden).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `CLK`  in  1  clock; all state changes on the rising edge.
  - `RESET`  in  1  reset, synchronous, active-high.
- Input side:
  - `IN_VALID`  in  1  operation request.
  - `IN_READY`  out  1  block can accept a request.
  - `OP`  in  4  operation select; encodings under Operation.
  - `DATA1`  in  WIDTH  operand A, or the value to shift.
  - `DATA2`  in  WIDTH  operand B; `DATA2[SHW-1:0]` is the shift amount.
- Output side:
  - `OUT_VALID`  out  1  one-cycle pulse: `RESULT` and flags are newly valid.
  - `RESULT`  out  WIDTH  registered result.
  - `ZERO`  out  1  `RESULT == 0`.
  - `NEG`  out  1  `RESULT[WIDTH-1]`.
  - `CARRY`  out  1  carry, borrow or shift-out; see below.
  - `OVERFLOW`  out  1  signed overflow for ADD and SUB.

## Operation
- `OP` encodings:
  - FWD = 0000, result DATA2.
  - ADD = 0001.
  - AND = 0010.
  - OR = 0011.
  - SUB = 0100, DATA1 − DATA2.
  - SLL = 0101.
  - SRL = 0110.
  - SRA = 0111.
  - ROR = 1000.
  - MUL = 1001, low WIDTH bits of the unsigned product.
  - Any other code executes as FWD.
- States:
  - IDLE: `IN_READY` = 1.
  - BUSY: iterating.
  - DONE: `OUT_VALID` = 1 for exactly one cycle.
- State transitions:
  - IDLE → DONE on accept of FWD, ADD, AND, OR, SUB, or of a shift/rotate with amount 0.
  - IDLE → BUSY on accept of a shift/rotate with amount n > 0, or of MUL.
  - BUSY → DONE after the last iteration.
  - DONE → IDLE unconditionally.
- Accept happens when `IN_VALID && IN_READY` at a rising edge. Operands and `OP` are captured then. `IN_VALID` outside IDLE is ignored; no request is queued.
- Shifts and rotate: one bit per BUSY cycle, n cycles in total. SRA replicates the MSB.
- MUL: shift-add, one multiplier bit per cycle, WIDTH BUSY cycles, internal 2·WIDTH accumulator.
- Flags are registered with `RESULT` in the same edge.
- `CARRY` by operation:
  - ADD: carry-out.
  - SUB: borrow, i.e. DATA1 < DATA2 unsigned.
  - SLL, SRL, SRA: last bit shifted out; 0 if n = 0.
  - MUL: 1 if the high half of the product is nonzero.
  - All others: 0.
- `OVERFLOW`: two's-complement overflow for ADD and SUB; 0 for all other operations.
- `RESULT` and the flags hold their value until the next DONE.
- Reset, including mid-operation:
  - State → IDLE.
  - `RESULT` = 0; `ZERO`, `NEG`, `CARRY`, `OVERFLOW`, `OUT_VALID` = 0.
  - The operation in flight is discarded, with no `OUT_VALID`.
  - `IN_READY` = 1 in the first cycle after reset.

## Timing
- Latency is counted from the accepting edge to the edge at which `OUT_VALID` is first sampled high:
  - Single-cycle ops: 1.
  - Shift or rotate by n: n + 1.
  - MUL: WIDTH + 1.
- Issue interval is latency + 1, because DONE is followed by IDLE. Back-to-back single-cycle ops therefore accept every 2 cycles.
- `IN_READY` is a decode of the state register only, with no combinational path from `IN_VALID`.
- All outputs are driven from registers.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum with the `OP` encodings above.
  - `alu_state_t` enum {IDLE, BUSY, DONE}.
  - Localparams `OP_W` = 4.
- Sub-module `alu_comb_unit`: combinational FWD/ADD/AND/OR/SUB with carry, borrow and overflow, parametrised by WIDTH.
- The top level holds the FSM, iteration counter, shift register and multiply accumulator.

## Test plan
All scenarios use WIDTH = 8.
1. ADD 0x7F + 0x01 → `OUT_VALID` at +1; `RESULT` 0x80, NEG = 1, OVERFLOW = 1, CARRY = 0, ZERO = 0.
2. SUB 0x05 − 0x05, then SUB 0x03 − 0x04 →
   - first: 0x00, ZERO = 1, CARRY = 0;
   - second: 0xFF, CARRY = 1, NEG = 1;
   - the second request is accepted 2 cycles after the first.
3. SRA 0x90 by 3 → `RESULT` 0xF2, CARRY = 0 at +4. SLL 0x81 by 0 → 0x81 at +1. ROR 0x81 by 1 → 0xC0 at +2.
4. MUL 0x0F × 0x11 → 0xFF, CARRY = 0 at +9. MUL 0x10 × 0x10 → 0x00, ZERO = 1, CARRY = 1.
5. `IN_VALID` held high with changing operands during a MUL → `IN_READY` = 0 throughout BUSY/DONE; the result reflects the captured operands only.
6. `RESET` asserted for 1 cycle at the 4th BUSY cycle of a MUL → next cycle IDLE, all outputs 0, no `OUT_VALID`; a following ADD 2 + 3 → 0x05 at +1.
7. Undefined `OP` = 1111, DATA2 = 0x5A → `RESULT` 0x5A at +1.
